// File: rtl/data_ram.sv
// Data memory stage: word-organised synchronous RAM with byte-lane steering,
// sticky misalignment flag and a 16-byte MMIO window (LED register, cycle counter).
module data_ram #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ram_address,
  input  logic        ram_enable,
  input  logic [31:0] ram_write_data,
  input  logic        ram_write_enable,
  input  logic [2:0]  ram_write_mode,
  input  logic        ram_read_enable,
  input  logic [2:0]  ram_read_mode,
  output logic [31:0] ram_read_data,
  output logic [31:0] led,
  output logic        misaligned
);
  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {REG_NONE, REG_RAM, REG_MMIO} region_e;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q, mmio_q, cycle_cnt;
  logic [1:0]  alo_q;
  logic [2:0]  rmode_q;
  logic        rden_q;
  region_e     region_q;

  logic            is_mmio, is_ram, w_mis, r_mis, mis_evt;
  logic [1:0]      alo;
  logic [3:0]      be, ram_be, led_be;
  logic [31:0]     wdata, word;
  logic [IDX_W-1:0] idx;
  region_e         region;

  assign alo     = ram_address[1:0];
  assign idx     = ram_address[IDX_W+1:2];
  assign is_mmio = (ram_address >= MMIO_BASE) && (ram_address <= MMIO_BASE + 32'd15);
  assign is_ram  = !is_mmio && ({1'b0, ram_address} < RAM_BYTES);
  assign region  = is_mmio ? REG_MMIO : (is_ram ? REG_RAM : REG_NONE);

  assign w_mis = ((ram_write_mode == 3'b001) && alo[0]) ||
                 ((ram_write_mode == 3'b010) && (alo != 2'b00));
  assign r_mis = ((ram_read_mode[1:0] == 2'b01) && alo[0]) ||
                 ((ram_read_mode == 3'b010) && (alo != 2'b00));
  // Unmapped accesses never raise the flag
  assign mis_evt = ram_enable && (is_ram || is_mmio) &&
                   ((ram_write_enable && w_mis) || (ram_read_enable && r_mis));

  always_comb begin
    be    = 4'b0000;
    wdata = ram_write_data;
    case (ram_write_mode)
      3'b000: begin be = 4'b0001 << alo; wdata = {4{ram_write_data[7:0]}}; end
      3'b001: begin be = alo[1] ? 4'b1100 : 4'b0011; wdata = {2{ram_write_data[15:0]}}; end
      3'b010: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(ram_enable && ram_write_enable) || w_mis || reset)
      be = 4'b0000;
  end

  assign ram_be = is_ram ? be : 4'b0000;
  assign led_be = (is_mmio && (ram_address[3:2] == 2'b00)) ? be : 4'b0000;

  // Array port is not reset; read-before-write falls out of the NBA ordering
  always_ff @(posedge clk) begin
    if (ram_enable) begin
      ram_q <= mem[idx];
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      led        <= '0;
      misaligned <= 1'b0;
      alo_q      <= '0;
      rmode_q    <= '0;
      rden_q     <= 1'b0;
      region_q   <= REG_NONE;
      mmio_q     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      for (int i = 0; i < 4; i++)
        if (led_be[i]) led[8*i +: 8] <= wdata[8*i +: 8];
      if (mis_evt) misaligned <= 1'b1;
      if (ram_enable) begin
        alo_q    <= alo;
        rmode_q  <= ram_read_mode;
        rden_q   <= ram_read_enable && !r_mis;
        region_q <= region;
        case (ram_address[3:2])
          2'b00:   mmio_q <= led;
          2'b01:   mmio_q <= cycle_cnt;
          default: mmio_q <= '0;
        endcase
      end
    end
  end

  always_comb begin
    word = '0;
    if (region_q == REG_MMIO)     word = mmio_q;
    else if (region_q == REG_RAM) word = ram_q;
    ram_read_data = '0;
    if (rden_q) begin
      case (rmode_q)
        3'b000, 3'b100: ram_read_data = {24'd0, word[8*alo_q +: 8]};
        3'b001, 3'b101: ram_read_data = {16'd0, alo_q[1] ? word[31:16] : word[15:0]};
        3'b010:         ram_read_data = word;
        default:        ram_read_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: directed plan steps then random traffic against a byte-addressed model.
module tb_data_ram;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ram_address = '0;
  logic        ram_enable = 1'b0;
  logic [31:0] ram_write_data = '0;
  logic        ram_write_enable = 1'b0;
  logic [2:0]  ram_write_mode = '0;
  logic        ram_read_enable = 1'b0;
  logic [2:0]  ram_read_mode = '0;
  logic [31:0] ram_read_data, led;
  logic        misaligned;

  int total = 0;
  int bad = 0;

  logic [7:0] mb [0:63];
  logic [7:0] lb [0:3];

  data_ram #(.DEPTH_WORDS(4096), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .ram_address(ram_address), .ram_enable(ram_enable),
    .ram_write_data(ram_write_data), .ram_write_enable(ram_write_enable),
    .ram_write_mode(ram_write_mode), .ram_read_enable(ram_read_enable),
    .ram_read_mode(ram_read_mode), .ram_read_data(ram_read_data), .led(led),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [2:0] wm,
                     input logic [31:0] wd, input logic re, input logic [2:0] rm);
    ram_address = a; ram_write_enable = we; ram_write_mode = wm; ram_write_data = wd;
    ram_read_enable = re; ram_read_mode = rm; ram_enable = 1'b1;
    @(posedge clk); #1;
    ram_enable = 1'b0; ram_write_enable = 1'b0; ram_read_enable = 1'b0;
  endtask

  // Model: little-endian byte store; sizes derived from mode, invalid modes size 0
  function automatic int rsz(input logic [2:0] m);
    case (m)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic int wsz(input logic [2:0] m);
    return (m == 3'b000) ? 1 : (m == 3'b001) ? 2 : (m == 3'b010) ? 4 : 0;
  endfunction

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    if (a < 64) return mb[a];
    if (a >= MB && a < MB + 4) return lb[a - MB];
    return 8'h00;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input logic [2:0] m);
    int n = rsz(m);
    logic [31:0] v = '0;
    if (n == 0 || (a % n) != 0) return '0;
    for (int k = 0; k < n; k++) v = v | (32'(mbyte(a + k)) << (8 * k));
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [2:0] m, input logic [31:0] d);
    int n = wsz(m);
    if (n == 0 || (a % n) != 0) return;
    for (int k = 0; k < n; k++) begin
      if (a + k < 64) mb[a + k] = d[8*k +: 8];
      else if (a + k >= MB && a + k < MB + 4) lb[a + k - MB] = d[8*k +: 8];
    end
  endtask

  initial begin
    logic [31:0] c1, a, d, e;
    logic [2:0]  wm, rm;
    logic        we, re;

    repeat (2) @(posedge clk); #1;
    chk("reset_rd", ram_read_data, 32'h0);
    chk("reset_led", led, 32'h0);
    chk("reset_mis", {31'd0, misaligned}, 32'h0);
    reset = 1'b0;

    req(32'h100, 1, 3'b010, 32'hDEADBEEF, 0, 3'b000);
    req(32'h100, 0, 3'b000, 0, 1, 3'b010);
    chk("lw_100", ram_read_data, 32'hDEADBEEF);
    req(32'h101, 0, 3'b000, 0, 1, 3'b100);
    chk("lbu_101", ram_read_data, 32'h000000BE);
    req(32'h102, 0, 3'b000, 0, 1, 3'b101);
    chk("lhu_102", ram_read_data, 32'h0000DEAD);

    req(32'h103, 1, 3'b000, 32'h0000005A, 0, 3'b000);
    req(32'h100, 0, 3'b000, 0, 1, 3'b010);
    chk("sb_103", ram_read_data, 32'h5AADBEEF);
    req(32'h100, 1, 3'b001, 32'h00001234, 0, 3'b000);
    req(32'h100, 0, 3'b000, 0, 1, 3'b010);
    chk("sh_100", ram_read_data, 32'h5AAD1234);

    // Stall: inputs wiggle with enable low
    for (int i = 0; i < 3; i++) begin
      ram_address = 32'h100; ram_write_enable = 1'b1; ram_write_mode = 3'b010;
      ram_write_data = $urandom; ram_read_enable = 1'b1; ram_read_mode = 3'($urandom);
      @(posedge clk); #1;
      chk("stall_hold", ram_read_data, 32'h5AAD1234);
    end
    ram_write_enable = 1'b0; ram_read_enable = 1'b0;
    req(32'h100, 0, 3'b000, 0, 1, 3'b010);
    chk("stall_nowrite", ram_read_data, 32'h5AAD1234);
    chk("mis_clear", {31'd0, misaligned}, 32'h0);

    req(32'h102, 1, 3'b010, 32'h11111111, 0, 3'b000);
    chk("mis_set", {31'd0, misaligned}, 32'h1);
    req(32'h100, 0, 3'b000, 0, 1, 3'b010);
    chk("mis_suppressed", ram_read_data, 32'h5AAD1234);
    req(32'h102, 0, 3'b000, 0, 1, 3'b010);
    chk("mis_read_zero", ram_read_data, 32'h0);

    req(MB, 1, 3'b010, 32'h0000000F, 0, 3'b000);
    chk("led_write", led, 32'h0000000F);
    req(MB + 4, 1, 3'b010, 32'hFFFFFFFF, 1, 3'b010);
    c1 = ram_read_data;
    repeat (9) @(posedge clk); #1;
    req(MB + 4, 0, 3'b000, 0, 1, 3'b010);
    chk("cycle_diff", ram_read_data - c1, 32'd10);
    req(MB + 8, 1, 3'b010, 32'hABCD0123, 1, 3'b010);
    chk("mmio_8_zero", ram_read_data, 32'h0);
    chk("led_untouched", led, 32'h0000000F);

    req(32'h4000, 1, 3'b010, 32'hCAFEF00D, 0, 3'b000);
    req(32'h4000, 0, 3'b000, 0, 1, 3'b010);
    chk("unmapped_zero", ram_read_data, 32'h0);

    // Random traffic over 16 RAM words plus the LED register
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      req(32'(4 * w), 1, 3'b010, d, 0, 3'b000);
      mstore(32'(4 * w), 3'b010, d);
    end
    lb[0] = 8'h0F; lb[1] = 8'h00; lb[2] = 8'h00; lb[3] = 8'h00;
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 4) == 0) ? MB + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 63));
      wm = 3'($urandom_range(0, 3));
      rm = 3'($urandom);
      we = 1'($urandom);
      re = 1'($urandom);
      d  = $urandom;
      e  = re ? mload(a, rm) : 32'h0;
      req(a, we, wm, d, re, rm);
      if (we) mstore(a, wm, d);
      chk($sformatf("rand_rd a=%h rm=%0d", a, rm), ram_read_data, e);
      chk("rand_led", led, {lb[3], lb[2], lb[1], lb[0]});
    end

    // Reset wins over a pending store
    reset = 1'b1;
    ram_address = 32'h100; ram_write_enable = 1'b1; ram_write_mode = 3'b010;
    ram_write_data = 32'h12345678; ram_read_enable = 1'b1; ram_read_mode = 3'b010;
    ram_enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ram_enable = 1'b0; ram_write_enable = 1'b0; ram_read_enable = 1'b0;
    chk("rst_rd", ram_read_data, 32'h0);
    chk("rst_led", led, 32'h0);
    chk("rst_mis", {31'd0, misaligned}, 32'h0);
    req(MB + 4, 0, 3'b000, 0, 1, 3'b010);
    chk("rst_cycle0", ram_read_data, 32'h0);
    req(32'h100, 0, 3'b000, 0, 1, 3'b010);
    chk("rst_ram_kept", ram_read_data, 32'h5AAD1234);
    req(MB + 4, 0, 3'b000, 0, 1, 3'b010);
    chk("rst_cycle2", ram_read_data, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
